// File: rtl/result_display_pkg.sv
// Shared definitions for the result display block.
// Holds the 4-bit digit codes held in the display registers, the active-low
// seven-segment glyphs (bit order g,f,e,d,c,b,a), the result width, the
// largest displayable magnitude, the conversion FSM state type and the
// double-dabble / digit-formatting helpers.
package result_display_pkg;

    localparam int RES_W   = 11;
    localparam int MAX_MAG = 999;

    localparam logic [3:0] DIG_0     = 4'd0;
    localparam logic [3:0] DIG_1     = 4'd1;
    localparam logic [3:0] DIG_2     = 4'd2;
    localparam logic [3:0] DIG_3     = 4'd3;
    localparam logic [3:0] DIG_4     = 4'd4;
    localparam logic [3:0] DIG_5     = 4'd5;
    localparam logic [3:0] DIG_6     = 4'd6;
    localparam logic [3:0] DIG_7     = 4'd7;
    localparam logic [3:0] DIG_8     = 4'd8;
    localparam logic [3:0] DIG_9     = 4'd9;
    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_E     = 4'd11;
    localparam logic [3:0] DIG_R     = 4'd12;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Display contents after reset: blank, blank, blank, '0' (digit3..digit0).
    localparam logic [15:0] DIGITS_RESET = {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABS,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in one bit.
    // Anything shifted out of the top nibble only occurs for magnitudes > 999,
    // which are shown as an error anyway.
    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic in_bit);
        logic [11:0] adj;
        adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[10:0], in_bit};
    endfunction

    // BCD hundreds/tens/units -> {digit3, digit2, digit1, digit0} codes with
    // leading-zero blanking and the sign in the leftmost position.
    function automatic logic [15:0] format_digits(input logic [11:0] bcd,
                                                  input logic err, input logic neg);
        logic [3:0] d3, d2, d1;
        if (err) return {DIG_BLANK, DIG_E, DIG_R, DIG_R};
        d3 = (neg && (bcd != '0)) ? DIG_MINUS : DIG_BLANK;
        d2 = (bcd[11:8] == 4'd0) ? DIG_BLANK : bcd[11:8];
        d1 = (bcd[11:4] == 8'd0) ? DIG_BLANK : bcd[7:4];
        return {d3, d2, d1, bcd[3:0]};
    endfunction

endpackage

// File: rtl/result_display_seg7_decode.sv
// seg7_decode: combinational digit code -> active-low seven-segment glyph.
// Ports:
//   digit_i  4-bit digit code (0-9, MINUS, E, R, BLANK)
//   seg_o    glyph, bit order g,f,e,d,c,b,a, active-low
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_BLANK;
        unique case (digit_i)
            DIG_0:     seg_o = GLYPH_0;
            DIG_1:     seg_o = GLYPH_1;
            DIG_2:     seg_o = GLYPH_2;
            DIG_3:     seg_o = GLYPH_3;
            DIG_4:     seg_o = GLYPH_4;
            DIG_5:     seg_o = GLYPH_5;
            DIG_6:     seg_o = GLYPH_6;
            DIG_7:     seg_o = GLYPH_7;
            DIG_8:     seg_o = GLYPH_8;
            DIG_9:     seg_o = GLYPH_9;
            DIG_MINUS: seg_o = GLYPH_MINUS;
            DIG_E:     seg_o = GLYPH_E;
            DIG_R:     seg_o = GLYPH_R;
            default:   seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// result_display: converts an 11-bit signed calculator result to decimal with
// a serial double-dabble FSM and drives a 4-digit multiplexed 7-seg display.
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   load   one-cycle strobe capturing value/ovf (ignored unless idle)
//   value  signed two's-complement result
//   ovf    overflow flag; forces the error display
//   seg    active-low segments g..a of the currently enabled digit
//   an     active-low digit enables, an[0] = units
//   busy   conversion in progress
//   done   one-cycle pulse when the new result is on the display
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RES_W-1:0] value,
    input  logic             ovf,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             busy,
    output logic             done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_e           state_q;
    logic [RES_W-1:0] val_q;
    logic             ovf_q;
    logic [9:0]       mag_q;
    logic             err_q;
    logic             neg_q;
    logic [11:0]      bcd_q;
    logic [3:0]       bit_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      digits_q, digits_d;

    logic [RES_W-1:0] mag_c;
    logic [11:0]      bcd_next;
    logic             dig_load;

    logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [3:0]       digit_sel;
    logic [6:0]       glyph_c;

    assign mag_c    = val_q[RES_W-1] ? (~val_q + 11'd1) : val_q;
    assign bcd_next = dd_step(bcd_q, mag_q[bit_q]);
    assign dig_load = (state_q == ST_SHIFT) && (bit_q == 4'd0);

    // Digit registers load with the final dabble step so the new result is
    // visible in the same cycle that done is high.
    always_comb begin
        digits_d = digits_q;
        if (rst)           digits_d = DIGITS_RESET;
        else if (dig_load) digits_d = format_digits(bcd_next, err_q, neg_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            mag_q   <= '0;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        val_q   <= value;
                        ovf_q   <= ovf;
                        busy_q  <= 1'b1;
                        state_q <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    // Magnitudes above 999 (incl. 1024) become errors, so only
                    // the low 10 bits ever need converting.
                    mag_q   <= mag_c[9:0];
                    err_q   <= ovf_q || (mag_c > 11'(MAX_MAG));
                    neg_q   <= val_q[RES_W-1];
                    bcd_q   <= '0;
                    bit_q   <= 4'd9;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_next;
                    if (bit_q == 4'd0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        bit_q <= bit_q - 4'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
        digits_q <= digits_d;
    end

    // Scan counter and digit index; reset is folded into the next-state values
    // so an/seg can be registered from them and always agree with each other.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        idx_d      = idx_q;
        if (rst) begin
            scan_cnt_d = '0;
            idx_d      = 2'd0;
        end else if (scan_cnt_q == CW'(REFRESH_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    assign digit_sel = digits_d[4*idx_d +: 4];

    seg7_decode u_seg7_decode (
        .digit_i (digit_sel),
        .seg_o   (glyph_c)
    );

    always_ff @(posedge clk) begin
        scan_cnt_q <= scan_cnt_d;
        idx_q      <= idx_d;
        an_q       <= ~(4'b0001 << idx_d);
        seg_q      <= glyph_c;
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
